uart_rx_sequencer: RTL and testbench

//   Receive-side controller for the UART RX path. Synchronises the serial line,

---
 rtl/uart_rx_sequencer.sv | 127 ++++++++++++
 tb/tb_uart_rx_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronises the serial line, times bit periods,
// and walks start / data / stop states. It emits each received word with a
// one-cycle valid strobe, or a frame_err strobe when the stop bit is bad.
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_d;
    logic [2:0]           flush;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // Two-flop synchroniser, one-cycle history for edge detection, and a
    // post-reset fill marker. The sync flops reset high, so until real line
    // samples have reached rxs_d a low line would look like a falling edge;
    // flush[2] blocks start detection until the history holds a true sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            flush   <= '0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
            flush   <= {flush[1:0], 1'b1};
        end
    end

    // Frame FSM with bit-period counter, shift register and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush[2] && rxs_d && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        data      <= shreg;
                        valid     <= rxs;
                        frame_err <= !rxs;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Testbench for uart_rx_sequencer: a table of frames, hand-written corner
// sequences (glitch, held-low line, back-to-back, mid-frame reset, odd bit
// period) and randomized frames checked against a frame-level model.
module tb_uart_rx_sequencer;

    localparam int C    = 16;
    localparam int H    = C / 2;
    localparam int NB   = 8;
    localparam int C6   = 5;
    localparam int H6   = C6 / 2;
    localparam int NB6  = 7;
    // rx drive -> strobe cycle: 3 sync/detect cycles, half bit, NB data bits + stop
    localparam int LAT  = 3 + H + (NB + 1) * C;

    logic          clk;
    logic          rst;
    logic          rx;
    logic [NB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    logic           rx6;
    logic [NB6-1:0] data6;
    logic           valid6;
    logic           frame_err6;
    logic           busy6;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       fe;
        logic       bz;
        logic       pbz;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       fe;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       exp_v;
        logic       exp_fe;
        logic [7:0] exp_d;
    } vec_t;

    ev_t  ev_q[$];
    ev_t  ev6_q[$];
    exp_t exp_q[$];
    vec_t tbl[6];

    logic pbusy, pvalid, pferr, pbusy6;
    int   dbl;
    int   busy_cnt;
    int   rise6_cyc;

    uart_rx_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(NB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    uart_rx_sequencer #(.CLKS_PER_BIT(C6), .DATA_BITS(NB6)) dut6 (
        .clk(clk), .rst(rst), .rx(rx6), .data(data6),
        .valid(valid6), .frame_err(frame_err6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every strobe with its cycle and busy context.
    always @(negedge clk) begin
        if (valid || frame_err)
            ev_q.push_back('{d: data, v: valid, fe: frame_err, bz: busy, pbz: pbusy, cyc: cyc});
        if ((valid && pvalid) || (frame_err && pferr) || (valid && frame_err))
            dbl++;
        if (busy)
            busy_cnt++;
        pbusy  = busy;
        pvalid = valid;
        pferr  = frame_err;
        if (valid6 || frame_err6)
            ev6_q.push_back('{d: {1'b0, data6}, v: valid6, fe: frame_err6, bz: busy6, pbz: pbusy6, cyc: cyc});
        if (busy6 && !pbusy6)
            rise6_cyc = cyc;
        pbusy6 = busy6;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance n clock edges and land just after the last one.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial frame on rx, called just after a clock edge; tfall = cycle of start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int tfall);
        rx = 1'b0;
        tfall = cyc;
        hold(C);
        for (int i = 0; i < NB; i++) begin
            rx = b[i];
            hold(C);
        end
        rx = stop;
        hold(C);
    endtask

    task automatic send_frame6(input logic [6:0] b, input logic stop, output int tfall);
        rx6 = 1'b0;
        tfall = cyc;
        hold(C6);
        for (int i = 0; i < NB6; i++) begin
            rx6 = b[i];
            hold(C6);
        end
        rx6 = stop;
        hold(C6);
    endtask

    // Frame-level reference: what a well-formed frame must produce and when.
    function automatic exp_t model(input logic [7:0] b, input logic stop, input int tfall);
        exp_t e;
        e.d   = b;
        e.v   = stop;
        e.fe  = !stop;
        e.cyc = tfall + 3 + H + (NB + 1) * C;
        return e;
    endfunction

    initial begin
        int t0, t1, gap;
        logic [7:0] b;
        logic stp;
        exp_t e;

        checks = 0; errors = 0; cyc = 0; dbl = 0; busy_cnt = 0; rise6_cyc = -1;
        pbusy = 1'b0; pvalid = 1'b0; pferr = 1'b0; pbusy6 = 1'b0;

        tbl[0] = '{din: 8'hA5, stop: 1'b1, exp_v: 1'b1, exp_fe: 1'b0, exp_d: 8'hA5};
        tbl[1] = '{din: 8'h3C, stop: 1'b0, exp_v: 1'b0, exp_fe: 1'b1, exp_d: 8'h3C};
        tbl[2] = '{din: 8'h00, stop: 1'b1, exp_v: 1'b1, exp_fe: 1'b0, exp_d: 8'h00};
        tbl[3] = '{din: 8'hFF, stop: 1'b1, exp_v: 1'b1, exp_fe: 1'b0, exp_d: 8'hFF};
        tbl[4] = '{din: 8'h01, stop: 1'b0, exp_v: 1'b0, exp_fe: 1'b1, exp_d: 8'h01};
        tbl[5] = '{din: 8'h80, stop: 1'b1, exp_v: 1'b1, exp_fe: 1'b0, exp_d: 8'h80};

        // Reset state
        rst = 1'b0; rx = 1'b1; rx6 = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("reset data", int'(data), 0);
        check("reset valid", int'(valid), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset busy", int'(busy), 0);
        check("reset busy6", int'(busy6), 0);
        hold(3);
        rst = 1'b0;
        hold(10);

        // Table-driven frames, each followed by idle line
        for (int i = 0; i < 6; i++) begin
            ev_q.delete();
            send_frame(tbl[i].din, tbl[i].stop, t0);
            rx = 1'b1;
            hold(2 * C);
            check($sformatf("tbl%0d strobe count", i), ev_q.size(), 1);
            if (ev_q.size() >= 1) begin
                check($sformatf("tbl%0d data", i), int'(ev_q[0].d), int'(tbl[i].exp_d));
                check($sformatf("tbl%0d valid", i), int'(ev_q[0].v), int'(tbl[i].exp_v));
                check($sformatf("tbl%0d frame_err", i), int'(ev_q[0].fe), int'(tbl[i].exp_fe));
                check($sformatf("tbl%0d busy at strobe", i), int'(ev_q[0].bz), 0);
                check($sformatf("tbl%0d busy before strobe", i), int'(ev_q[0].pbz), 1);
                check($sformatf("tbl%0d latency", i), ev_q[0].cyc - t0, LAT);
            end
        end

        // Short low glitch: START entered, rejected at mid-start-bit
        ev_q.delete();
        rx = 1'b0;
        busy_cnt = 0;
        hold(4);
        rx = 1'b1;
        hold(30);
        check("glitch strobes", ev_q.size(), 0);
        check("glitch busy cycles", busy_cnt, H);
        check("glitch busy after", int'(busy), 0);

        // Bad stop bit with the line left low: one frame_err, no re-trigger
        ev_q.delete();
        send_frame(8'h3C, 1'b0, t0);
        hold(100);
        check("lowline strobes", ev_q.size(), 1);
        if (ev_q.size() >= 1) begin
            check("lowline frame_err", int'(ev_q[0].fe), 1);
            check("lowline valid", int'(ev_q[0].v), 0);
            check("lowline data", int'(ev_q[0].d), 'h3C);
        end
        check("lowline busy", int'(busy), 0);
        rx = 1'b1;
        hold(20);
        check("lowline no rearm before fall", ev_q.size(), 1);
        send_frame(8'h81, 1'b1, t0);
        rx = 1'b1;
        hold(2 * C);
        check("lowline rearm strobes", ev_q.size(), 2);
        if (ev_q.size() >= 2) begin
            check("lowline rearm valid", int'(ev_q[1].v), 1);
            check("lowline rearm data", int'(ev_q[1].d), 'h81);
        end

        // Back-to-back frames with no idle time
        ev_q.delete();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        rx = 1'b1;
        hold(2 * C);
        check("b2b strobes", ev_q.size(), 2);
        if (ev_q.size() >= 2) begin
            check("b2b data0", int'(ev_q[0].d), 'h00);
            check("b2b data1", int'(ev_q[1].d), 'hFF);
            check("b2b valid both", int'(ev_q[0].v & ev_q[1].v), 1);
            check("b2b spacing", ev_q[1].cyc - ev_q[0].cyc, 10 * C);
        end

        // Reset during data bit 4; line held low across release
        ev_q.delete();
        b = 8'h77;
        rx = 1'b0;
        hold(C);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            hold(C);
        end
        rx = b[4];
        hold(C / 2);
        #3 rst = 1'b1;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst data", int'(data), 0);
        check("midrst valid", int'(valid), 0);
        check("midrst frame_err", int'(frame_err), 0);
        rx = 1'b0;
        hold(3);
        rst = 1'b0;
        hold(5);
        check("lowrelease busy", int'(busy), 0);
        hold(12 * C);
        check("lowrelease strobes", ev_q.size(), 0);
        rx = 1'b1;
        hold(20);
        send_frame(8'h5A, 1'b1, t0);
        rx = 1'b1;
        hold(2 * C);
        check("postrst strobes", ev_q.size(), 1);
        if (ev_q.size() >= 1) begin
            check("postrst data", int'(ev_q[0].d), 'h5A);
            check("postrst valid", int'(ev_q[0].v), 1);
        end

        // Randomized frames against the frame-level model
        ev_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            gap = stp ? $urandom_range(0, 20) : $urandom_range(2, 20);
            send_frame(b, stp, t0);
            exp_q.push_back(model(b, stp, t0));
            rx = 1'b1;
            hold(gap);
        end
        hold(2 * C);
        check("rand strobe count", ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            e = exp_q[i];
            check($sformatf("rand%0d data", i), int'(ev_q[i].d), int'(e.d));
            check($sformatf("rand%0d valid", i), int'(ev_q[i].v), int'(e.v));
            check($sformatf("rand%0d frame_err", i), int'(ev_q[i].fe), int'(e.fe));
            check($sformatf("rand%0d cycle", i), ev_q[i].cyc, e.cyc);
        end

        // Odd bit period, 7 data bits
        ev6_q.delete();
        rise6_cyc = -1;
        send_frame6(7'h55, 1'b1, t0);
        rx6 = 1'b1;
        hold(3 * C6);
        check("odd strobes", ev6_q.size(), 1);
        check("odd start entry", rise6_cyc - t0, 3);
        if (ev6_q.size() >= 1) begin
            check("odd data", int'(ev6_q[0].d), 'h55);
            check("odd valid", int'(ev6_q[0].v), 1);
            check("odd latency", ev6_q[0].cyc - rise6_cyc + 1, H6 + (NB6 + 1) * C6 + 1);
        end

        check("strobe exclusivity/width", dbl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
